// File: rtl/sjr_seq_pkg.sv
// Shared types and constants for the Synthesijer method-call sequencer.
package sjr_seq_pkg;

  localparam int unsigned CMD_W    = 4;
  localparam int unsigned STATUS_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  localparam logic [STATUS_W-1:0] ST_OK      = 2'b00;
  localparam logic [STATUS_W-1:0] ST_BADIDX  = 2'b01;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'b10;
  localparam logic [STATUS_W-1:0] ST_FINISH  = 2'b11;

endpackage

// File: rtl/sjr_method_sequencer_if.sv
// Command/completion channel plus per-method req/busy pairs of the sequencer.
interface sjr_method_sequencer_if
  import sjr_seq_pkg::*;
#(
  parameter int unsigned NUM_METHODS = 4,
  parameter int unsigned CNT_WIDTH   = 32
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [CMD_W-1:0]       cmd_method;
  logic [NUM_METHODS-1:0] method_req;
  logic [NUM_METHODS-1:0] method_busy;
  logic                   finish_flag;
  logic                   done_valid;
  logic [STATUS_W-1:0]    done_status;
  logic [CNT_WIDTH-1:0]   done_cycles;
  logic                   active;

  // Host / generated-object side
  modport master (
    output cmd_valid, cmd_method, method_busy, finish_flag,
    input  cmd_ready, method_req, done_valid, done_status, done_cycles, active
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_method, method_busy, finish_flag,
    output cmd_ready, method_req, done_valid, done_status, done_cycles, active
  );

endinterface

// File: rtl/sjr_sat_counter.sv
// Saturating up-counter with synchronous clear/enable; exposes its next value
// so the caller can capture the count of the completing cycle.
module sjr_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_count_nxt_c
);

  logic [CNT_WIDTH-1:0] r_count;

  // Clear wins over enable; hold at all-ones instead of wrapping
  always_comb begin
    o_count_nxt_c = r_count;
    if (i_clr) begin
      o_count_nxt_c = '0;
    end else if (i_en && (r_count != '1)) begin
      o_count_nxt_c = r_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_nxt_c;
    end
  end

endmodule

// File: rtl/sjr_method_sequencer.sv
// Issues one method call at a time into a Synthesijer object via req/busy and
// reports status plus elapsed cycles. Define SJR_SEQ_WATCHDOG_EN for the timeout.
module sjr_method_sequencer
  import sjr_seq_pkg::*;
#(
  parameter int unsigned NUM_METHODS = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  sjr_method_sequencer_if.slave bus
);

  if ((NUM_METHODS < 1) || (NUM_METHODS > 16) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("sjr_method_sequencer: NUM_METHODS must be 1..16 and TIMEOUT nonzero");
  end

  seq_state_t             r_state, w_state_nxt;
  logic [CMD_W-1:0]       r_idx, w_idx_nxt;
  logic                   r_fin, w_fin_nxt;
  logic [STATUS_W-1:0]    r_status, w_status_nxt;
  logic [CNT_WIDTH-1:0]   r_cycles, w_cycles_nxt;
  logic [CNT_WIDTH-1:0]   w_count_nxt;
  logic [NUM_METHODS-1:0] r_req, w_req_nxt, w_sel;
  logic                   r_cmd_ready, r_done_valid, r_active;
  logic                   w_accept, w_cnt_en, w_busy_sel, w_idx_ok;

  assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid && r_cmd_ready;
  assign w_cnt_en   = (r_state == S_ISSUE) || (r_state == S_RUN);
  assign w_idx_ok   = 32'(bus.cmd_method) < NUM_METHODS;
  // Busy of non-selected methods is masked off
  assign w_sel      = NUM_METHODS'(1) << r_idx;
  assign w_busy_sel = |(bus.method_busy & w_sel);

  sjr_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk           (clk),
    .rst           (reset),
    .i_clr         (w_accept),
    .i_en          (w_cnt_en),
    .o_count_nxt_c (w_count_nxt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_fin_nxt    = r_fin;
    w_status_nxt = r_status;
    w_cycles_nxt = r_cycles;
    w_req_nxt    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_idx_nxt = bus.cmd_method;
          w_fin_nxt = 1'b0;
          if (w_idx_ok) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt  = S_DONE;
            w_status_nxt = ST_BADIDX;
            w_cycles_nxt = '0;
          end
        end
      end
      S_ISSUE: begin
        w_fin_nxt = r_fin | bus.finish_flag;
        if (w_busy_sel) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_fin_nxt = r_fin | bus.finish_flag;
        if (!w_busy_sel) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = w_fin_nxt ? ST_FINISH : ST_OK;
          w_cycles_nxt = w_count_nxt;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef SJR_SEQ_WATCHDOG_EN
    // Timeout overrides a busy fall seen on the same edge
    if (w_cnt_en && (w_count_nxt == CNT_WIDTH'(TIMEOUT))) begin
      w_state_nxt  = S_DONE;
      w_status_nxt = ST_TIMEOUT;
      w_cycles_nxt = CNT_WIDTH'(TIMEOUT);
    end
`endif
    if (w_state_nxt == S_ISSUE) w_req_nxt = NUM_METHODS'(1) << w_idx_nxt;
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_fin        <= 1'b0;
      r_status     <= ST_OK;
      r_cycles     <= '0;
      r_req        <= '0;
      r_cmd_ready  <= 1'b1;
      r_done_valid <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_fin        <= w_fin_nxt;
      r_status     <= w_status_nxt;
      r_cycles     <= w_cycles_nxt;
      r_req        <= w_req_nxt;
      r_cmd_ready  <= (w_state_nxt == S_IDLE);
      r_done_valid <= (w_state_nxt == S_DONE);
      r_active     <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_RUN);
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.method_req  = r_req;
  assign bus.done_valid  = r_done_valid;
  assign bus.done_status = r_status;
  assign bus.done_cycles = r_cycles;
  assign bus.active      = r_active;

endmodule

// File: tb/tb_sjr_method_sequencer.sv
// Directed bench for sjr_method_sequencer; emulates the generated object's busy/finish.
module tb_sjr_method_sequencer;
  import sjr_seq_pkg::*;

  localparam int unsigned NM = 4;
  localparam int unsigned CW = 32;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sjr_method_sequencer_if #(.NUM_METHODS(NM), .CNT_WIDTH(CW)) bus ();

  sjr_method_sequencer #(
    .NUM_METHODS (NM),
    .CNT_WIDTH   (CW),
    .TIMEOUT     (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one request bit may ever be high
  always @(negedge clk) begin
    if (!reset) chk("onehot", 64'($countones(bus.method_req) <= 1), 64'(1));
  end

  // Issue one command, then play the target: busy high for cycles d..d+len-1
  // after accept, finish_flag pulsed at cycle fin_at.
  task automatic do_call(input logic [3:0] m, input int d, input int len, input int fin_at,
                         input bit noise, input int budget,
                         output int req_cyc, output int done_cnt, output int done_at,
                         output int ready_at, output logic [1:0] st, output logic [31:0] cyc);
    req_cyc = 0; done_cnt = 0; done_at = -1; ready_at = -1; st = '0; cyc = '0;
    bus.cmd_method = m;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (bus.method_req != '0) req_cyc++;
      if (bus.done_valid) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          st      = bus.done_status;
          cyc     = bus.done_cycles;
        end
      end else if (done_at >= 0 && ready_at < 0 && bus.cmd_ready) begin
        ready_at = n;
      end
      bus.method_busy = noise ? 4'b1111 : 4'b0000;
      if (m < 4) bus.method_busy[m[1:0]] = (n >= d) && (n < d + len);
      bus.finish_flag = (n == fin_at);
      tick();
    end
    bus.method_busy = '0;
    bus.finish_flag = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [3:0] m, input int d, input int len,
                         input int fin_at, input bit noise, input int exp_req,
                         input logic [1:0] exp_st, input int exp_cyc, input int exp_done_at);
    int req_cyc, done_cnt, done_at, ready_at, budget;
    logic [1:0]  st;
    logic [31:0] cyc;
    budget = (d + len + 5 > 40) ? 40 : d + len + 5;
    do_call(m, d, len, fin_at, noise, budget, req_cyc, done_cnt, done_at, ready_at, st, cyc);
    chk({tag, "_req_cycles"}, 64'(req_cyc), 64'(exp_req));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    chk({tag, "_status"}, 64'(st), 64'(exp_st));
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_done_at"}, 64'(done_at), 64'(exp_done_at));
    chk({tag, "_ready_at"}, 64'(ready_at), 64'(exp_done_at + 1));
    chk({tag, "_hold"}, 64'(bus.done_cycles), 64'(exp_cyc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int   acc, dn, rises, rem;
    bit   pending;
    logic prev;

    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_method  = '0;
    bus.method_busy = '0;
    bus.finish_flag = 1'b0;
    tick();
    tick();
    chk("rst_ready",  64'(bus.cmd_ready),   64'(1));
    chk("rst_req",    64'(bus.method_req),  64'(0));
    chk("rst_done",   64'(bus.done_valid),  64'(0));
    chk("rst_status", 64'(bus.done_status), 64'(0));
    chk("rst_cycles", 64'(bus.done_cycles), 64'(0));
    chk("rst_active", 64'(bus.active),      64'(0));
    reset = 1'b0;
    tick();

    //      tag           m  d  len fin noise req status     cyc done_at
    run_vec("m0_basic",   0, 1, 5,  -1, 0,    2,  ST_OK,     7,  7);
    run_vec("bad_idx",    7, 0, 0,  -1, 0,    0,  ST_BADIDX, 0,  0);
    run_vec("m2_finish",  2, 1, 4,  3,  0,    2,  ST_FINISH, 6,  6);
    run_vec("m2_clean",   2, 1, 4,  -1, 0,    2,  ST_OK,     6,  6);
    run_vec("min_call",   1, 0, 1,  -1, 0,    1,  ST_OK,     2,  2);
    run_vec("fin_issue",  1, 2, 1,  0,  0,    3,  ST_FINISH, 4,  4);
    run_vec("noise_m3",   3, 2, 2,  -1, 1,    3,  ST_OK,     5,  5);
`ifdef SJR_SEQ_WATCHDOG_EN
    run_vec("watchdog",   0, 0, 1000, -1, 0,  1,  ST_TIMEOUT, 20, 20);
`endif

    // Reset while ISSUE holds the request
    bus.cmd_method = 4'd1;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
    chk("rst_issue_req_pre", 64'(bus.method_req), 64'(4'b0010));
    #2 reset = 1'b1;
    #1;
    chk("rst_issue_req",   64'(bus.method_req), 64'(0));
    chk("rst_issue_ready", 64'(bus.cmd_ready),  64'(1));
    tick();
    reset = 1'b0;
    tick();

    // Reset during RUN: no completion may follow
    bus.cmd_method = 4'd2;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
    bus.method_busy = 4'b0100;
    tick();
    tick();
    chk("rst_run_active_pre", 64'(bus.active), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("rst_run_ready",  64'(bus.cmd_ready),  64'(1));
    chk("rst_run_active", 64'(bus.active),     64'(0));
    chk("rst_run_req",    64'(bus.method_req), 64'(0));
    tick();
    reset = 1'b0;
    bus.method_busy = '0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done_valid) dn++;
      tick();
    end
    chk("rst_run_no_done", 64'(dn), 64'(0));
    chk("rst_run_cycles",  64'(bus.done_cycles), 64'(0));
    run_vec("post_rst",   1, 0, 1,  -1, 0,    1,  ST_OK,     2,  2);

    // cmd_valid held high: target raises busy for 2 cycles after each req rise
    acc = 0; dn = 0; rises = 0; rem = 0; pending = 1'b0; prev = 1'b0;
    bus.cmd_method = 4'd1;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.done_valid) begin
        dn++;
        pending = 1'b0;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        chk("b2b_no_queue", 64'(pending), 64'(0));
        acc++;
        pending = 1'b1;
      end
      chk("b2b_ready_excl", 64'(bus.cmd_ready & (bus.active | bus.done_valid)), 64'(0));
      bus.method_busy = (rem > 0) ? 4'b0010 : 4'b0000;
      if (rem > 0) rem--;
      if (bus.method_req[1] && !prev) begin
        rises++;
        rem = 2;
      end
      prev = bus.method_req[1];
      tick();
    end
    bus.cmd_valid   = 1'b0;
    bus.method_busy = '0;
    chk("b2b_accepts", 64'(acc),   64'(5));
    chk("b2b_dones",   64'(dn),    64'(5));
    chk("b2b_rises",   64'(rises), 64'(5));
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sjr_method_sequencer.md
# sjr_method_sequencer

Controller that sequences method calls into a Synthesijer-generated object (e.g. PrimeSim) through its per-method `*_req`/`*_busy` handshake. It accepts one command at a time from a host or testbench, raises the selected method's request, tracks busy until completion, and reports a completion record with status and elapsed cycles. It sits between the simulation or host control logic and the generated module's method ports, replacing hard-tied `run_req`/`start_req` constants.

## Interface
- `NUM_METHODS`, 4: number of method handshake pairs driven (1..16).
- `CNT_WIDTH`, 32: width of the elapsed-cycle counter.
- `TIMEOUT`, 1000000: watchdog limit in cycles (used only with watchdog compiled in).

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: sequencer idle and able to accept.
- `cmd_method` in 4: method index to invoke.
- `method_req` out NUM_METHODS: one-hot request to the target's `<m>_req` inputs.
- `method_busy` in NUM_METHODS: target's `<m>_busy` outputs.
- `finish_flag` in 1: target's `finish_flag_out`.
- `done_valid` out 1: one-cycle completion pulse.
- `done_status` out 2: 00 ok, 01 bad index, 10 timeout, 11 ok with finish_flag seen during the call.
- `done_cycles` out CNT_WIDTH: cycles from ISSUE entry to completion; valid with `done_valid`, held until the next completion.
- `active` out 1: high in ISSUE or RUN.

## Operation
- States: IDLE, ISSUE, RUN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_method`. If index < NUM_METHODS, go to ISSUE. Otherwise go to DONE with status 01 and cycles 0.
- ISSUE: `method_req[idx]`=1; all other bits 0. Hold until `method_busy[idx]`=1 is sampled, then go to RUN. `req` deasserts on RUN entry.
- RUN: wait for `method_busy[idx]`=0, then go to DONE.
- DONE: pulse `done_valid` for one cycle and return to IDLE. `cmd_ready` stays 0 in DONE.
- Counter: cleared on command accept. Increments every cycle in ISSUE and RUN. Saturates at all-ones and never wraps.
- `finish_flag` is sampled every cycle in ISSUE and RUN. Sticky per call; selects status 11 instead of 00. Cleared on accept.
- Only one request bit may ever be high. `method_req` is all-zero outside ISSUE.
- Busy bits of non-selected methods are ignored.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1, `method_req`=0, `done_valid`=0, `done_status`=00, `done_cycles`=0, `active`=0.
  - Reset mid-call drops `req` immediately. No done pulse is produced.
- Accept at edge T puts the FSM in ISSUE for cycle T+1, with `req` high from T+1.
- If busy is sampled high at edge T+k, `req` is low from T+k+1.
- If busy is sampled low at edge T+m, `done_valid` is high during cycle T+m+1 and `cmd_ready` is high again at T+m+2.
- Minimum call (busy high for one cycle): accept to `done_valid` = 3 cycles; `done_cycles`=2.
- Bad index: `done_valid` is high in the cycle after accept.
- `cmd_valid` during busy states is ignored, not queued.

## Configuration
- `SJR_SEQ_WATCHDOG_EN` defined:
  - In ISSUE or RUN, when the counter reaches `TIMEOUT`, drop `req` and go to DONE with status 10 and `done_cycles`=TIMEOUT.
  - The target is left as-is; the host must reset it.
  - The timeout takes priority over busy falling in the same cycle.
- Not defined: no watchdog logic; status 10 is never produced. The FSM may wait indefinitely, with the counter saturating.

## Structure
- Package `sjr_seq_pkg`:
  - state encoding constants (IDLE=0..DONE=3);
  - status codes `ST_OK`, `ST_BADIDX`, `ST_TIMEOUT`, `ST_FINISH`.
- Sub-module `sjr_sat_counter`: CNT_WIDTH saturating counter with synchronous clear and enable, and async reset. Instantiated once.

## Test plan
- Method 0 with busy high 1 cycle after req, for 5 cycles -> req high exactly 2 cycles, `done_valid` once, status 00, `done_cycles`=7.
- `cmd_method`=7 with NUM_METHODS=4 -> no `req` ever, `done_valid` next cycle, status 01, cycles 0.
- Method 2 call with `finish_flag` pulsed mid-RUN -> status 11; an immediately following clean call returns 00.
- With `SJR_SEQ_WATCHDOG_EN` and TIMEOUT=20, busy stuck high -> `done_valid` with status 10, cycles 20, `req` low, `cmd_ready` restored.
- `reset` asserted during RUN -> `method_req`=0 and `cmd_ready`=1 asynchronously, no `done_valid`; the next command completes normally.
- Back-to-back `cmd_valid` held high -> second command accepted only after `done_valid`; `method_req` never has more than one bit set.
